// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, formats, FSM states,
// PC source encodings and the decoded-instruction record.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_MOV     = 4'b0000;
  localparam alu_op_t OP_NOT     = 4'b0001;
  localparam alu_op_t OP_ADD     = 4'b0010;
  localparam alu_op_t OP_SUB     = 4'b0011;
  localparam alu_op_t OP_OR      = 4'b0100;
  localparam alu_op_t OP_AND     = 4'b0101;
  localparam alu_op_t OP_SLT     = 4'b0111;
  localparam alu_op_t OP_LI      = 4'b1001;
  localparam alu_op_t OP_LW_ADDR = 4'b1010;
  localparam alu_op_t OP_SW_ADDR = 4'b1010;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_MEM = 2'b10,
    FMT_CTL = 2'b11
  } fmt_e;

  localparam logic [3:0] FN_LW   = 4'b1010;
  localparam logic [3:0] FN_SW   = 4'b1011;
  localparam logic [3:0] FN_BEQ  = 4'b0000;
  localparam logic [3:0] FN_BNE  = 4'b0001;
  localparam logic [3:0] FN_JUMP = 4'b0010;
  localparam logic [3:0] FN_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_MEM, CLS_BEQ, CLS_BNE, CLS_JUMP, CLS_NONE
  } iclass_e;

  typedef struct packed {
    alu_op_t alu_ctrl;
    logic    alu_src_b;
    iclass_e iclass;
    logic    is_lw;
    logic    is_sw;
    logic    illegal;
    logic    is_halt;
  } dec_t;

  // R-type accepts the base ALU set; I-type additionally accepts li.
  function automatic logic is_alu_fn(input logic [3:0] fn, input logic allow_li);
    logic ok;
    ok = 1'b0;
    case (fn)
      OP_MOV, OP_NOT, OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT: ok = 1'b1;
      OP_LI:   ok = allow_li;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: maps fmt/fn onto the ALU opcode, operand-B
// select, instruction class and the illegal/halt flags.
module alu_seq_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  fmt_e       fmt;
  logic [3:0] fn;
  logic       fn_lw;
  logic       fn_sw;
  logic       unused_fields;

  assign fmt           = fmt_e'(instr[31:30]);
  assign fn            = instr[29:26];
  assign fn_lw         = (fn == FN_LW);
  assign fn_sw         = (fn == FN_SW);
  // Register fields are consumed by the datapath, not by the sequencer.
  assign unused_fields = ^instr[25:0];

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    dec          = '0;
    dec.alu_ctrl = OP_MOV;
    dec.iclass   = CLS_NONE;
    unique case (fmt)
      FMT_R: begin
        dec.iclass   = CLS_ALU;
        dec.alu_ctrl = fn;
        dec.illegal  = !is_alu_fn(fn, 1'b0);
      end
      FMT_I: begin
        dec.iclass    = CLS_ALU;
        dec.alu_ctrl  = fn;
        dec.alu_src_b = 1'b1;
        dec.illegal   = !is_alu_fn(fn, 1'b1);
      end
      FMT_MEM: begin
        dec.iclass    = CLS_MEM;
        dec.alu_src_b = 1'b1;
        dec.is_lw     = fn_lw;
        dec.is_sw     = fn_sw;
        dec.alu_ctrl  = fn_lw ? OP_LW_ADDR : OP_SW_ADDR;
        dec.illegal   = !(fn_lw || fn_sw);
      end
      FMT_CTL: begin
        case (fn)
          FN_BEQ: begin
            dec.iclass   = CLS_BEQ;
            dec.alu_ctrl = OP_SUB;
          end
          FN_BNE: begin
            dec.iclass   = CLS_BNE;
            dec.alu_ctrl = OP_SUB;
          end
          FN_JUMP: dec.iclass  = CLS_JUMP;
          FN_HALT: dec.is_halt = 1'b1;
          default: dec.illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) driving the ALU control
// interface. Define ALU_SEQ_PERF_EN to add the retire counter and its port.
module alu_seq_ctrl
  import alu_pkg::*;
`ifdef ALU_SEQ_PERF_EN
#(
  parameter int unsigned RETIRE_W = 32
)
`endif
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [3:0]          alu_ctrl,
  output logic                alu_src_b,
  output logic                ir_we,
  output logic                pc_we,
  output logic                rf_we,
  output logic                mem_re,
  output logic                mem_we,
  output logic [1:0]          pc_src,
  output logic                wb_sel,
`ifdef ALU_SEQ_PERF_EN
  output logic [RETIRE_W-1:0] retire_cnt,
`endif
  output logic                halted,
  output logic                trap
);

  state_e state_q, state_d;
  dec_t   dec_d, dec_q;
  logic   retire;
  logic   unused_dec;

  alu_seq_decode u_decode (
    .instr (instr),
    .dec   (dec_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) dec_q <= dec_d;
    end
  end

  // The decode is latched once so EXEC/MEM/WB stay Moore even if instr changes.
  always_comb begin
    state_d   = state_q;
    alu_ctrl  = OP_MOV;
    alu_src_b = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    pc_src    = PC_INC;
    wb_sel    = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_re = 1'b1;
        ir_we  = mem_ready;
        pc_we  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_d.illegal)      state_d = S_TRAP;
        else if (dec_d.is_halt) state_d = S_HALT;
        else                    state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_ctrl  = dec_q.alu_ctrl;
        alu_src_b = dec_q.alu_src_b;
        unique case (dec_q.iclass)
          CLS_ALU: state_d = S_WB;
          CLS_MEM: state_d = S_MEM;
          CLS_BEQ, CLS_BNE: begin
            if (zero == (dec_q.iclass == CLS_BEQ)) begin
              pc_we  = 1'b1;
              pc_src = PC_BRANCH;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          CLS_JUMP: begin
            pc_we   = 1'b1;
            pc_src  = PC_JUMP;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        alu_ctrl  = dec_q.alu_ctrl;
        alu_src_b = dec_q.alu_src_b;
        mem_re    = dec_q.is_lw;
        mem_we    = dec_q.is_sw;
        if (mem_ready) begin
          retire  = dec_q.is_sw;
          state_d = dec_q.is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        wb_sel  = dec_q.is_lw;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT, S_TRAP: state_d = state_q;
    endcase
  end

  assign halted     = (state_q == S_HALT);
  assign trap       = (state_q == S_TRAP);
  assign unused_dec = dec_q.illegal ^ dec_q.is_halt;

`ifdef ALU_SEQ_PERF_EN
  logic [RETIRE_W-1:0] retire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retire_q <= '0;
    else if (retire) retire_q <= retire_q + RETIRE_W'(1);
  end

  assign retire_cnt = retire_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: an instruction-level model emits the expected
// per-cycle outputs, a compare process checks them at every falling edge.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  alu_ctrl;
  logic        alu_src_b, ir_we, pc_we, rf_we, mem_re, mem_we, wb_sel, halted, trap;
  logic [1:0]  pc_src;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] retire_cnt;
`endif

  alu_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_ctrl   (alu_ctrl),
    .alu_src_b  (alu_src_b),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .rf_we      (rf_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .pc_src     (pc_src),
    .wb_sel     (wb_sel),
`ifdef ALU_SEQ_PERF_EN
    .retire_cnt (retire_cnt),
`endif
    .halted     (halted),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src_b;
    logic       ir_we;
    logic       pc_we;
    logic       rf_we;
    logic       mem_re;
    logic       mem_we;
    logic [1:0] pc_src;
    logic       wb_sel;
    logic       halted;
    logic       trap;
  } obs_t;

  typedef struct {
    obs_t        o;
    bit          alu_dc;
    int unsigned ret;
  } exp_t;

  typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_JMP, K_HALT, K_ILL} kind_e;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          fw;
    int          mw;
    int          lat;
  } vec_t;

  obs_t        act;
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          m_halted, m_trap;
  int unsigned m_ret;

  assign act = {alu_ctrl, alu_src_b, ir_we, pc_we, rf_we, mem_re, mem_we, pc_src, wb_sel,
                halted, trap};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction semantics straight from the encoding table.
  function automatic void classify(input logic [31:0] ins, output kind_e k, output logic [3:0] op);
    logic [1:0] f;
    logic [3:0] n;
    f  = ins[31:30];
    n  = ins[29:26];
    k  = K_ILL;
    op = 4'h0;
    case (f)
      2'b00: if (n inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7}) begin k = K_R; op = n; end
      2'b01: if (n inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9}) begin k = K_I; op = n; end
      2'b10: begin
        if (n == 4'hA)      begin k = K_LW; op = 4'hA; end
        else if (n == 4'hB) begin k = K_SW; op = 4'hA; end
      end
      default: begin
        if (n == 4'h0)      begin k = K_BEQ; op = 4'h3; end
        else if (n == 4'h1) begin k = K_BNE; op = 4'h3; end
        else if (n == 4'h2) k = K_JMP;
        else if (n == 4'hF) k = K_HALT;
      end
    endcase
  endfunction

  // One clock cycle: drive inputs, queue what the outputs must be during it.
  task automatic cycle(input logic mr, input logic z, input obs_t o, input bit dc);
    exp_t e;
    mem_ready = mr;
    zero      = z;
    o.halted  = m_halted;
    o.trap    = m_trap;
    e.o       = o;
    e.alu_dc  = dc;
    e.ret     = m_ret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic z, input int fw, input int mw,
                           output int ncyc);
    kind_e k;
    logic [3:0] op;
    obs_t o;
    bit taken;
    classify(ins, k, op);
    instr = ins;
    ncyc  = 0;
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mem_re = 1'b1;
      cycle(1'b0, rbit(), o, 1'b0); ncyc++;
    end
    o = '0; o.mem_re = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
    cycle(1'b1, rbit(), o, 1'b0); ncyc++;
    o = '0;
    cycle(rbit(), rbit(), o, 1'b0); ncyc++;
    if (k == K_HALT) begin m_halted = 1'b1; return; end
    if (k == K_ILL)  begin m_trap = 1'b1;   return; end
    o = '0;
    o.alu_ctrl  = op;
    o.alu_src_b = (k inside {K_I, K_LW, K_SW});
    taken = (k == K_BEQ && z) || (k == K_BNE && !z);
    if (taken)      begin o.pc_we = 1'b1; o.pc_src = 2'b01; end
    if (k == K_JMP) begin o.pc_we = 1'b1; o.pc_src = 2'b10; end
    cycle(rbit(), z, o, k == K_JMP); ncyc++;
    if (k inside {K_BEQ, K_BNE, K_JMP}) begin m_ret++; return; end
    if (k inside {K_LW, K_SW}) begin
      o.mem_re = (k == K_LW);
      o.mem_we = (k == K_SW);
      for (int i = 0; i < mw; i++) begin
        cycle(1'b0, rbit(), o, 1'b0); ncyc++;
      end
      cycle(1'b1, rbit(), o, 1'b0); ncyc++;
      if (k == K_SW) begin m_ret++; return; end
    end
    o = '0; o.rf_we = 1'b1; o.wb_sel = (k == K_LW);
    cycle(rbit(), rbit(), o, 1'b0); ncyc++;
    m_ret++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b1;
    m_halted  = 1'b0;
    m_trap    = 1'b0;
    m_ret     = 0;
    @(posedge clk);
    #1;
    check("reset_outputs", 32'(act), 32'd0);
`ifdef ALU_SEQ_PERF_EN
    check("reset_retire", retire_cnt, 32'd0);
`endif
    rst = 1'b0;
    cycle(rbit(), rbit(), obs_t'(0), 1'b0);
  endtask

  initial begin : compare
    exp_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = act;
        if (e.alu_dc) begin a.alu_ctrl = '0; e.o.alu_ctrl = '0; end
        check("cycle_outputs", 32'(a), 32'(e.o));
`ifdef ALU_SEQ_PERF_EN
        check("cycle_retire", retire_cnt, e.ret);
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       tbl[10];
    logic [31:0] ill[5];
    int          ill_len[5];
    int          n;
    obs_t        o;

    tbl[0] = '{32'h0822_1800, 1'b0, 0, 0, 4};  // add
    tbl[1] = '{32'hA822_0004, 1'b1, 0, 2, 7};  // lw, two MEM stalls
    tbl[2] = '{32'hC002_1800, 1'b1, 0, 0, 3};  // beq taken
    tbl[3] = '{32'hC002_1800, 1'b0, 0, 0, 3};  // beq not taken
    tbl[4] = '{32'hC402_1800, 1'b0, 0, 0, 3};  // bne taken
    tbl[5] = '{32'hC402_1800, 1'b1, 0, 0, 3};  // bne not taken
    tbl[6] = '{32'hAC22_0010, 1'b0, 0, 0, 4};  // sw
    tbl[7] = '{32'h6420_1234, 1'b1, 1, 0, 5};  // li, one FETCH stall
    tbl[8] = '{32'hC800_0ABC, 1'b0, 0, 0, 3};  // jump
    tbl[9] = '{32'h1C22_1800, 1'b0, 2, 0, 6};  // slt, two FETCH stalls

    ill[0] = 32'hD800_0000; ill_len[0] = 20;
    ill[1] = 32'h1800_0000; ill_len[1] = 3;
    ill[2] = 32'h6800_0000; ill_len[2] = 3;
    ill[3] = 32'h8800_0000; ill_len[3] = 3;
    ill[4] = 32'h2400_0000; ill_len[4] = 3;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].ins, tbl[i].z, tbl[i].fw, tbl[i].mw, n);
      check($sformatf("latency_%0d", i), 32'(n), 32'(tbl[i].lat));
      check($sformatf("refetch_%0d", i), 32'(mem_re), 32'd1);
    end
    run_instr(32'hFC00_0000, rbit(), 0, 0, n);
    check("halted_set", 32'(halted), 32'd1);
`ifdef ALU_SEQ_PERF_EN
    check("retire_total", retire_cnt, 32'd10);
`endif
    for (int i = 0; i < 5; i++) cycle(rbit(), rbit(), obs_t'(0), 1'b0);
    check("halted_sticky", 32'(halted), 32'd1);

    for (int t = 0; t < 5; t++) begin
      do_reset();
      run_instr(ill[t], rbit(), 0, 0, n);
      for (int i = 0; i < ill_len[t]; i++) cycle(rbit(), rbit(), obs_t'(0), 1'b0);
      check($sformatf("trap_%0d", t), 32'(trap), 32'd1);
      check($sformatf("trap_not_halt_%0d", t), 32'(halted), 32'd0);
    end

    // Reset pulsed while a store is waiting in MEM.
    do_reset();
    instr = 32'hAC22_0010;
    o = '0; o.mem_re = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
    cycle(1'b1, rbit(), o, 1'b0);
    cycle(rbit(), rbit(), obs_t'(0), 1'b0);
    o = '0; o.alu_ctrl = 4'hA; o.alu_src_b = 1'b1;
    cycle(rbit(), rbit(), o, 1'b0);
    o.mem_we = 1'b1;
    cycle(1'b0, rbit(), o, 1'b0);
    check("sw_mem_we_before_rst", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("sw_mem_we_async_drop", 32'(mem_we), 32'd0);
    check("sw_outputs_in_rst", 32'(act), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    m_halted = 1'b0;
    m_trap   = 1'b0;
    m_ret    = 0;
    cycle(1'b0, rbit(), obs_t'(0), 1'b0);
    o = '0; o.mem_re = 1'b1;
    cycle(1'b0, rbit(), o, 1'b0);
    check("fetch_after_rst", 32'(mem_re), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle control sequencer for the 32-bit datapath: it decodes the instruction register and drives the ALU operation code, operand-B select, memory strobes and register/PC write enables, and consumes the ALU `zero` flag to resolve branches. It is the producer side of the ALU control interface. Each instruction is stepped through fetch, decode, execute, memory and writeback states, with a ready handshake to instruction/data memory.

## Interface
- `RETIRE_W`, default 32: width of the retire counter, present only with the perf macro.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr`  in  32  instruction register contents; valid from DECODE onward.
- `zero`  in  1  ALU equality flag, 1 when operand A == operand B.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `alu_ctrl`  out  4  ALU operation code.
- `alu_src_b`  out  1  0 = register rt, 1 = sign-extended imm16.
- `ir_we`, `pc_we`, `rf_we`, `mem_re`, `mem_we`  out  1 each  write and access strobes.
- `pc_src`  out  2  00 = pc+1, 01 = pc+1+imm16, 10 = instr[25:0].
- `wb_sel`  out  1  0 = ALU result, 1 = memory data.
- `halted`, `trap`  out  1 each  sticky status flags.
- `retire_cnt`  out  `RETIRE_W`  instructions retired; present only with the perf macro.

## Operation
- Field layout:
  - fmt = instr[31:30], fn = instr[29:26].
  - rd = [25:21], rs = [20:16], rt = [15:11], imm16 = [15:0].
- fmt 00, R-type: `alu_ctrl` = fn. Legal fn values: 0000 mov, 0001 not, 0010 add, 0011 sub, 0100 or, 0101 and, 0111 slt.
- fmt 01, I-type: same fn set, plus 1001 li. Drives `alu_src_b` = 1.
- fmt 10, memory: fn 1010 lw, fn 1011 sw. Both drive `alu_ctrl` = 1010 (address add) with `alu_src_b` = 1.
- fmt 11, control flow:
  - fn 0000 beq, fn 0001 bne: `alu_ctrl` = 0011 on rs, rt.
  - fn 0010 jump.
  - fn 1111 halt.
- Any other fmt/fn combination is illegal and goes to TRAP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- Transitions:
  - IDLE→FETCH unconditionally.
  - FETCH holds until `mem_ready`, then →DECODE.
  - DECODE→EXEC, or →TRAP if illegal, or →HALT if halt.
  - EXEC→WB for R/I, →MEM for lw/sw, →FETCH for branch/jump.
  - MEM holds until `mem_ready`, then →WB for lw, →FETCH for sw.
  - WB→FETCH.
- HALT and TRAP are absorbing. Only `rst` leaves them.
- Output rules:
  - FETCH: `mem_re` = 1. `ir_we` = `pc_we` = `mem_ready`, with `pc_src` = 00.
  - EXEC: `alu_ctrl` and `alu_src_b` from decode.
  - EXEC, beq with `zero` = 1 or bne with `zero` = 0: `pc_we` = 1, `pc_src` = 01.
  - EXEC, jump: `pc_we` = 1, `pc_src` = 10.
  - MEM: `alu_ctrl` and `alu_src_b` held. `mem_re` for lw, `mem_we` for sw, both held until `mem_ready`.
  - WB: `rf_we` = 1. `wb_sel` = 1 for lw, else 0.
- In every state other than EXEC and MEM, `alu_ctrl` = 0000.

## Timing
- Reset: state = IDLE.
  - Outputs while `rst` is high and in IDLE: all strobes 0, `alu_ctrl` = 0000, `pc_src` = 00, `alu_src_b` = `wb_sel` = 0.
  - `halted` = `trap` = 0, `retire_cnt` = 0.
- Outputs are Moore functions of state and the stored decode. Exceptions: `ir_we`/`pc_we` in FETCH, `pc_we` in EXEC and the retire increment in MEM for sw (gated by `mem_ready` or `zero`).
- Minimum latency with `mem_ready` tied high:
  - R/I: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch/jump: 3 cycles.
- Each cycle with `mem_ready` low in FETCH or MEM adds exactly one cycle.
- `zero` is sampled only in EXEC. Its value in any other state is ignored.
- `rst` asserted mid-instruction: strobes drop immediately (asynchronous) and the state returns to IDLE. No partial writes follow reset release.
- `retire_cnt` increments when retiring: on the WB→FETCH edge, on EXEC→FETCH for branch/jump, and on MEM→FETCH for sw. At all-ones it wraps to 0. Halt and illegal instructions do not count.

## Configuration
- `ALU_SEQ_PERF_EN` defined: `retire_cnt` port and counter present.
- `ALU_SEQ_PERF_EN` undefined: no port, no counter. All other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - ALU op constants: OP_MOV..OP_SW_ADDR.
  - fmt codes.
  - state enum.
  - pc_src encodings.
- One combinational sub-module, `alu_seq_decode`: `instr` → {`alu_ctrl`, `alu_src_b`, class, is_lw, is_sw, illegal, is_halt}.
- The FSM lives in the top module.

## Test plan
- Reset release, `mem_ready` = 1, instr = R add (fmt 00, fn 0010):
  - FETCH, DECODE, EXEC with `alu_ctrl` = 0010 and `alu_src_b` = 0, then WB with `rf_we` = 1.
  - Back in FETCH 4 cycles after the first FETCH.
- lw, with `mem_ready` low for 2 cycles in MEM: MEM holds 3 cycles with `mem_re` = 1 and `alu_ctrl` = 1010; then WB with `wb_sel` = 1. Total 7 cycles.
- beq with `zero` = 1 → EXEC `pc_we` = 1, `pc_src` = 01. Same instruction with `zero` = 0 → `pc_we` = 0. bne with the inverse values.
- instr = 0xC000_0000 | fn 0110 (illegal) → `trap` = 1 from the cycle after DECODE; strobes stay 0 for 20 cycles.
- `rst` pulsed in MEM during sw with `mem_we` = 1 → `mem_we` = 0 immediately; IDLE then FETCH after release.
- With `ALU_SEQ_PERF_EN`: 10 mixed legal instructions followed by a halt → `retire_cnt` = 10, `halted` = 1.
